fetch_unit: RTL

Instruction fetch stage directly upstream of the cpu core. It drives the instruction memory through a single-outstanding req/ack handshake and buffers fetched bytes in a small prefetch queue. It presents {instr, instr_pc} to the core's decode input over a valid/ready handshake. Branch and jump redirects from the core flush the queue and restart fetch at a new PC.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 16;
    localparam int FETCH_INSTR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetched {instr, pc} entries; flush wins over push.
// The head reads as zero while the FIFO is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    // Entry storage; data is not reset, the pointers define what is live.
    always_ff @(posedge clock) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory fetch feeding a small
// prefetch queue toward the core, with redirect flush/restart.
// Optional macro FETCH_BYPASS_EN forwards an ack straight to the core output
// when the queue is empty (zero-cycle ack-to-valid).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               ADDR_W      = FETCH_ADDR_W,
    parameter int               INSTR_W     = FETCH_INSTR_W,
    parameter int               QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(QUEUE_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    fetch_state_e     state;
    fetch_state_e     state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0] q_count;
    entry_t           q_head;
    entry_t           q_wdata;
    logic             ack_req;
    logic             q_valid;
    logic             bypass;
    logic             deq;
    logic             q_push;
    logic             q_pop;
    logic [CNT_W:0]   count_after;

    fetch_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clock (clock),
        .reset (reset),
        .flush (redirect_valid),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .count (q_count),
        .head  (q_head)
    );

    // Output selection, queue push/pop decisions and FSM next state.
    always_comb begin
        ack_req = (state == REQ) && mem_ack;
        q_valid = (q_count != '0);
        bypass  = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass  = ack_req && !redirect_valid && !q_valid;
`endif
        instr_valid = q_valid || bypass;
        instr       = bypass ? mem_rdata : q_head.instr;
        instr_pc    = bypass ? mem_addr  : q_head.pc;

        // Redirect outranks both consumption and capture of the ack data.
        deq    = instr_valid && instr_ready && !redirect_valid;
        q_pop  = deq && q_valid;
        q_push = ack_req && !redirect_valid && !(bypass && instr_ready);
        q_wdata.instr = mem_rdata;
        q_wdata.pc    = mem_addr;

        count_after = {1'b0, q_count} + {{CNT_W{1'b0}}, q_push} - {{CNT_W{1'b0}}, q_pop};

        state_next = state;
        case (state)
            IDLE: begin
                // A request is only issued when its result already owns a slot.
                if (!redirect_valid && ({1'b0, q_count} < DEPTH_EXT))
                    state_next = REQ;
            end
            REQ: begin
                if (redirect_valid)
                    state_next = mem_ack ? IDLE : DROP;
                else if (mem_ack)
                    state_next = (count_after < DEPTH_EXT) ? REQ : IDLE;
            end
            DROP: begin
                if (mem_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Fetch PC and the address held on the memory port while a request is open.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
        end else begin
            if (redirect_valid)
                fetch_pc <= redirect_pc;
            else if (ack_req)
                fetch_pc <= mem_addr + ADDR_ONE;

            if (state == IDLE && state_next == REQ)
                mem_addr <= fetch_pc;
            else if (ack_req && state_next == REQ)
                mem_addr <= mem_addr + ADDR_ONE;
        end
    end

    assign mem_req = (state != IDLE);

endmodule
